// File: rtl/dm_pkg.sv
//------------------------------------------------------------------------------
// Module : dm_pkg
// Brief  : Shared definitions for the data-memory arbiter: store-size codes,
//          FSM state encoding and the alignment check used on every access.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package dm_pkg;

  // Store/load size codes, identical to the memory's SWSrc select.
  // Both 2'b10 and 2'b11 mean "byte"; only bit 1 matters for that case.
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  // Access sequencer states
  localparam int                 STATE_W     = 2;
  localparam logic [STATE_W-1:0] c_ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] c_ST_ACCESS = 2'd1;
  localparam logic [STATE_W-1:0] c_ST_RESP   = 2'd2;

  // A word must sit on a 4-byte boundary, a half on a 2-byte boundary.
  // Bytes can never be misaligned.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic w_mis;
    w_mis = 1'b0;
    case (size)
      SZ_WORD: w_mis = (addr_lo != 2'b00);
      SZ_HALF: w_mis = addr_lo[0];
      default: w_mis = 1'b0;
    endcase
    return w_mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
//------------------------------------------------------------------------------
// Module : rr_arb2
// Brief  : Two-way round-robin picker. A lone requester wins outright; on a
//          tie the requester that was not granted last time wins.
// Ports  : i_valid[1:0]  request vector
//          i_last_grant  index of the most recent winner
//          o_grant[1:0]  one-hot grant (all zero when nobody requests)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      // Tie: hand the port to whoever did not have it last.
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dm_arbiter.sv
//------------------------------------------------------------------------------
// Module : dm_arbiter
// Brief  : Shares the single data-memory port between requester 0 (pipeline
//          MEM stage) and requester 1 (debug/DMA). Round-robin arbitration,
//          one registered access per three cycles:
//            IDLE   - grant and latch a request (ready pulses to the winner)
//            ACCESS - drive memory; write only if aligned; capture read data
//            RESP   - one-cycle response pulse to the winner
// Ports  : clk, rst               clock, synchronous active-high reset
//          reqN_valid/ready       request handshake (N = 0, 1)
//          reqN_addr/wdata/we/size request fields, held stable until ready
//          rspN_valid/rdata/err   registered response to requester N
//          dm_addr/din/DMWr/SWSrc memory-side drive
//          dm_dout                memory read word (combinational of dm_addr)
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W = 12,
  // Fixed at 32: the size encoding assumes four bytes per word.
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_we,
  input  logic [1:0]        req0_size,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_we,
  input  logic [1:0]        req1_size,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,

  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_DMWr,
  output logic [1:0]        dm_SWSrc,
  input  logic [DATA_W-1:0] dm_dout
);

  //--------------------------------------------------------------------------
  // Declarations
  //--------------------------------------------------------------------------
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next_state;

  logic               r_last_grant;   // index of the most recent winner
  logic               r_port;         // winner of the request in flight

  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic               r_we;
  logic [1:0]         r_size;

  logic               r_rsp0_valid;
  logic               r_rsp1_valid;
  logic [DATA_W-1:0]  r_rsp0_rdata;
  logic [DATA_W-1:0]  r_rsp1_rdata;
  logic               r_rsp0_err;
  logic               r_rsp1_err;

  logic [1:0]         w_grant;
  logic               w_accept;
  logic               w_misaligned;
  logic [DATA_W-1:0]  w_rsp_data;

  logic [ADDR_W-1:0]  w_req_addr;
  logic [DATA_W-1:0]  w_req_wdata;
  logic               w_req_we;
  logic [1:0]         w_req_size;

  //--------------------------------------------------------------------------
  // Arbitration
  //--------------------------------------------------------------------------
  rr_arb2 u_rr_arb2 (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // A grant only counts in IDLE and never while reset is being applied,
  // so a requester cannot see ready for a request that will be discarded.
  assign w_accept = (r_state == c_ST_IDLE) && !rst && (w_grant != 2'b00);

  // Select the winning request's fields for latching.
  assign w_req_addr  = w_grant[1] ? req1_addr  : req0_addr;
  assign w_req_wdata = w_grant[1] ? req1_wdata : req0_wdata;
  assign w_req_we    = w_grant[1] ? req1_we    : req0_we;
  assign w_req_size  = w_grant[1] ? req1_size  : req0_size;

  //--------------------------------------------------------------------------
  // Access checks on the latched request
  //--------------------------------------------------------------------------
  assign w_misaligned = is_misaligned(r_size, r_addr[1:0]);

  // Stores and rejected accesses return zero; loads return the memory word.
  assign w_rsp_data = (r_we || w_misaligned) ? '0 : dm_dout;

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next-state logic
  //--------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:   w_next_state = (w_grant != 2'b00) ? c_ST_ACCESS : c_ST_IDLE;
      c_ST_ACCESS: w_next_state = c_ST_RESP;
      c_ST_RESP:   w_next_state = c_ST_IDLE;
      default:     w_next_state = c_ST_IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    dm_DMWr    = 1'b0;
    if (w_accept) begin
      req0_ready = w_grant[0];
      req1_ready = w_grant[1];
    end
    // Gating with rst drops the write of a request caught by reset in ACCESS.
    if ((r_state == c_ST_ACCESS) && r_we && !w_misaligned && !rst) begin
      dm_DMWr = 1'b1;
    end
  end

  //--------------------------------------------------------------------------
  // Request latch, grant history and registered response
  //--------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= 1'b1;   // requester 0 wins the first tie
      r_port       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_we         <= 1'b0;
      r_size       <= SZ_WORD;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_err   <= 1'b0;
    end else begin
      // Responses are single-cycle pulses: clear unless set below.
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp1_rdata <= '0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_err   <= 1'b0;

      // The latched fields double as the memory drive, so they hold their
      // last value whenever the FSM is not in ACCESS.
      if (w_accept) begin
        r_port       <= w_grant[1];
        r_last_grant <= w_grant[1];
        r_addr       <= w_req_addr;
        r_wdata      <= w_req_wdata;
        r_we         <= w_req_we;
        r_size       <= w_req_size;
      end

      if (r_state == c_ST_ACCESS) begin
        if (r_port) begin
          r_rsp1_valid <= 1'b1;
          r_rsp1_rdata <= w_rsp_data;
          r_rsp1_err   <= w_misaligned;
        end else begin
          r_rsp0_valid <= 1'b1;
          r_rsp0_rdata <= w_rsp_data;
          r_rsp0_err   <= w_misaligned;
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Output assignments
  //--------------------------------------------------------------------------
  assign dm_addr    = r_addr;
  assign dm_din     = r_wdata;
  assign dm_SWSrc   = r_size;

  assign rsp0_valid = r_rsp0_valid;
  assign rsp0_rdata = r_rsp0_rdata;
  assign rsp0_err   = r_rsp0_err;
  assign rsp1_valid = r_rsp1_valid;
  assign rsp1_rdata = r_rsp1_rdata;
  assign rsp1_err   = r_rsp1_err;

endmodule

`default_nettype wire

// File: tb/tb_dm_arbiter.sv
//------------------------------------------------------------------------------
// Module : tb_dm_arbiter
// Brief  : Self-checking bench for dm_arbiter. A behavioural 4 KB memory sits
//          on the dm_* port; a transaction-level model (request queues, a
//          phase counter and a byte-array shadow memory) predicts every
//          handshake, memory drive and response cycle by cycle.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dm_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req0_valid = 1'b0, req1_valid = 1'b0;
  logic              req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_addr = '0, req1_addr = '0;
  logic [DATA_W-1:0] req0_wdata = '0, req1_wdata = '0;
  logic              req0_we = 1'b0, req1_we = 1'b0;
  logic [1:0]        req0_size = 2'b00, req1_size = 2'b00;
  logic              rsp0_valid, rsp1_valid, rsp0_err, rsp1_err;
  logic [DATA_W-1:0] rsp0_rdata, rsp1_rdata;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_din, dm_dout;
  logic              dm_DMWr;
  logic [1:0]        dm_SWSrc;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_we(req0_we), .req0_size(req0_size),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_we(req1_we), .req1_size(req1_size),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .dm_addr(dm_addr), .dm_din(dm_din), .dm_DMWr(dm_DMWr),
    .dm_SWSrc(dm_SWSrc), .dm_dout(dm_dout)
  );

  //--------------------------------------------------------------------------
  // Behavioural data memory (little-endian, word-indexed by addr[11:2])
  //--------------------------------------------------------------------------
  logic [31:0] env_mem [0:1023];
  assign dm_dout = env_mem[dm_addr[11:2]];

  always @(posedge clk) begin
    if (dm_DMWr) begin
      if (dm_SWSrc == 2'b00)
        env_mem[dm_addr[11:2]] <= dm_din;
      else if (dm_SWSrc == 2'b01)
        env_mem[dm_addr[11:2]][{dm_addr[1], 4'b0000} +: 16] <= dm_din[15:0];
      else
        env_mem[dm_addr[11:2]][{dm_addr[1:0], 3'b000} +: 8] <= dm_din[7:0];
    end
  end

  //--------------------------------------------------------------------------
  // Reference model state
  //--------------------------------------------------------------------------
  typedef struct packed {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [1:0]  size;
  } req_t;

  req_t        q0[$], q1[$];          // pending requests per requester
  logic [7:0]  sh [0:4095];           // shadow memory, byte addressed
  int          m_phase;               // 0 idle, 1 access, 2 respond
  int          m_last, m_port;
  logic [11:0] m_addr;
  logic [31:0] m_din, m_rdata;
  logic [1:0]  m_size;
  logic        m_we, m_err;
  logic        rst_drive;
  int          cyc;

  // Observations used by the directed checks
  int          grant_log[$];
  int          grant_time[$];
  logic [31:0] last_rdata [2];
  logic        last_err [2];
  int          rsp_count [2];
  int          dmwr_seen;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit model_mis(input logic [1:0] sz, input logic [11:0] a);
    int ai;
    ai = int'(a);
    return (sz == 2'd0 && (ai % 4) != 0) || (sz == 2'd1 && (ai % 2) != 0);
  endfunction

  function automatic req_t mk(input int a, input logic [31:0] d, input bit we, input int sz);
    req_t r;
    r.addr = 12'(a); r.wdata = d; r.we = we; r.size = 2'(sz);
    return r;
  endfunction

  //--------------------------------------------------------------------------
  // One clock cycle: drive, compare against the model, advance the model.
  // Entered and left at posedge+1.
  //--------------------------------------------------------------------------
  task automatic step();
    int   g;
    int   a;
    req_t r;
    rst        = rst_drive;
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    if (q0.size() > 0) begin
      req0_addr = q0[0].addr; req0_wdata = q0[0].wdata;
      req0_we = q0[0].we; req0_size = q0[0].size;
    end
    if (q1.size() > 0) begin
      req1_addr = q1[0].addr; req1_wdata = q1[0].wdata;
      req1_we = q1[0].we; req1_size = q1[0].size;
    end
    @(negedge clk);

    g = -1;
    if (m_phase == 0 && !rst_drive) begin
      if (q0.size() > 0 && q1.size() > 0) g = (m_last == 1) ? 0 : 1;
      else if (q0.size() > 0)             g = 0;
      else if (q1.size() > 0)             g = 1;
    end
    check("ready0", 32'(req0_ready), 32'(g == 0));
    check("ready1", 32'(req1_ready), 32'(g == 1));
    if (req0_ready) begin grant_log.push_back(0); grant_time.push_back(cyc); end
    if (req1_ready) begin grant_log.push_back(1); grant_time.push_back(cyc); end

    check("dm_DMWr", 32'(dm_DMWr),
          32'(m_phase == 1 && m_we && !model_mis(m_size, m_addr) && !rst_drive));
    if (dm_DMWr) dmwr_seen++;
    check("dm_addr",  32'(dm_addr),  32'(m_addr));
    check("dm_din",   dm_din,        m_din);
    check("dm_SWSrc", 32'(dm_SWSrc), 32'(m_size));

    check("rsp0_valid", 32'(rsp0_valid), 32'(m_phase == 2 && m_port == 0));
    check("rsp1_valid", 32'(rsp1_valid), 32'(m_phase == 2 && m_port == 1));
    if (m_phase == 2 && m_port == 0) begin
      check("rsp0_rdata", rsp0_rdata, m_rdata);
      check("rsp0_err", 32'(rsp0_err), 32'(m_err));
    end
    if (m_phase == 2 && m_port == 1) begin
      check("rsp1_rdata", rsp1_rdata, m_rdata);
      check("rsp1_err", 32'(rsp1_err), 32'(m_err));
    end
    if (rsp0_valid) begin rsp_count[0]++; last_rdata[0] = rsp0_rdata; last_err[0] = rsp0_err; end
    if (rsp1_valid) begin rsp_count[1]++; last_rdata[1] = rsp1_rdata; last_err[1] = rsp1_err; end

    if (rst_drive) begin
      m_phase = 0; m_last = 1; m_addr = '0; m_din = '0; m_size = '0; m_we = 1'b0;
    end else begin
      case (m_phase)
        0: if (g >= 0) begin
             r = (g == 0) ? q0.pop_front() : q1.pop_front();
             m_port = g; m_last = g;
             m_addr = r.addr; m_din = r.wdata; m_we = r.we; m_size = r.size;
             m_phase = 1;
           end
        1: begin
             m_err = model_mis(m_size, m_addr);
             a = int'(m_addr) - (int'(m_addr) % 4);
             if (m_we || m_err) m_rdata = '0;
             else m_rdata = {sh[a+3], sh[a+2], sh[a+1], sh[a]};
             if (m_we && !m_err) begin
               a = int'(m_addr);
               sh[a] = m_din[7:0];
               if (m_size == 2'd0 || m_size == 2'd1) sh[a+1] = m_din[15:8];
               if (m_size == 2'd0) begin sh[a+2] = m_din[23:16]; sh[a+3] = m_din[31:24]; end
             end
             m_phase = 2;
           end
        default: m_phase = 0;
      endcase
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_phase != 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(q0.size() > 0 || q1.size() > 0 || m_phase != 0), 32'd0);
  endtask

  task automatic do_reset();
    q0.delete(); q1.delete();
    rst_drive = 1'b1;
    step(); step();
    rst_drive = 1'b0;
  endtask

  //--------------------------------------------------------------------------
  // Stimulus
  //--------------------------------------------------------------------------
  initial begin
    int snap_dmwr, snap_r0, snap_r1, snap_g;
    for (int i = 0; i < 1024; i++) env_mem[i] = '0;
    for (int i = 0; i < 4096; i++) sh[i] = '0;
    m_phase = 0; m_last = 1; m_port = 0; m_addr = '0; m_din = '0; m_size = '0;
    m_we = 1'b0; m_err = 1'b0; m_rdata = '0; cyc = 0; dmwr_seen = 0;
    rsp_count[0] = 0; rsp_count[1] = 0;
    last_rdata[0] = '0; last_rdata[1] = '0; last_err[0] = 1'b0; last_err[1] = 1'b0;
    rst_drive = 1'b1;
    @(posedge clk); #1;

    // Reset state
    step(); step();
    check("rst_rsp0_rdata", rsp0_rdata, 32'd0);
    check("rst_rsp1_rdata", rsp1_rdata, 32'd0);
    check("rst_rsp_err", 32'({rsp1_err, rsp0_err}), 32'd0);
    rst_drive = 1'b0;

    // Word store then load
    q0.push_back(mk(12'h010, 32'hDEADBEEF, 1'b1, 0));
    drain(20);
    check("st_rdata", last_rdata[0], 32'd0);
    check("st_err", 32'(last_err[0]), 32'd0);
    check("st_latency", 32'(dmwr_seen), 32'd1);
    q0.push_back(mk(12'h010, 32'h0, 1'b0, 0));
    drain(20);
    check("ld_word", last_rdata[0], 32'hDEADBEEF);

    // Sub-word stores
    q0.push_back(mk(12'h012, 32'h00001234, 1'b1, 1));
    q0.push_back(mk(12'h011, 32'h000000AB, 1'b1, 2));
    q0.push_back(mk(12'h010, 32'h0, 1'b0, 0));
    drain(30);
    check("ld_subword", last_rdata[0], 32'h1234ABEF);

    // Misaligned accesses write nothing
    snap_dmwr = dmwr_seen;
    q0.push_back(mk(12'h013, 32'hFFFFFFFF, 1'b1, 0));
    drain(20);
    check("mis_word_err", 32'(last_err[0]), 32'd1);
    q1.push_back(mk(12'h011, 32'h0000FFFF, 1'b1, 1));
    drain(20);
    check("mis_half_err", 32'(last_err[1]), 32'd1);
    check("mis_no_write", 32'(dmwr_seen - snap_dmwr), 32'd0);
    q0.push_back(mk(12'h010, 32'h0, 1'b0, 0));
    drain(20);
    check("mis_mem_same", last_rdata[0], 32'h1234ABEF);
    q0.push_back(mk(12'h013, 32'h00000055, 1'b1, 2));
    drain(20);
    check("byte_13_err", 32'(last_err[0]), 32'd0);
    q0.push_back(mk(12'h010, 32'h0, 1'b0, 0));
    drain(20);
    check("byte_13_ld", last_rdata[0], 32'h5534ABEF);

    // Contention from reset: grants alternate starting with requester 0
    do_reset();
    grant_log.delete(); grant_time.delete();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(16 + 4 * i, 32'h0, 1'b0, 0));
      q1.push_back(mk(64 + 4 * i, 32'h0, 1'b0, 0));
    end
    snap_r0 = rsp_count[0]; snap_r1 = rsp_count[1];
    drain(40);
    check("cont_grants", 32'(grant_log.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      check($sformatf("cont_grant%0d", i),
            32'((i < grant_log.size()) ? grant_log[i] : -1), 32'(i % 2));
    check("cont_gap", 32'((grant_time.size() > 1) ? grant_time[1] - grant_time[0] : -1), 32'd3);
    check("cont_rsp0", 32'(rsp_count[0] - snap_r0), 32'd3);
    check("cont_rsp1", 32'(rsp_count[1] - snap_r1), 32'd3);

    // Reset during the ACCESS cycle of a store: dropped, no write, no response
    q1.push_back(mk(12'h040, 32'h0, 1'b0, 0));
    drain(20);                               // leaves last_grant = 1
    q0.push_back(mk(12'h020, 32'hCAFEF00D, 1'b1, 0));
    snap_r0 = rsp_count[0]; snap_dmwr = dmwr_seen;
    step();                                  // grant
    rst_drive = 1'b1;
    step();                                  // ACCESS with reset
    rst_drive = 1'b0;
    q0.delete();
    repeat (3) step();
    check("rstmid_no_rsp", 32'(rsp_count[0] - snap_r0), 32'd0);
    check("rstmid_no_wr", 32'(dmwr_seen - snap_dmwr), 32'd0);
    check("rstmid_mem", env_mem[8], 32'd0);
    grant_log.delete();
    q0.push_back(mk(12'h020, 32'h0, 1'b0, 0));
    q1.push_back(mk(12'h024, 32'h0, 1'b0, 0));
    step();
    check("rstmid_tie", 32'((grant_log.size() > 0) ? grant_log[0] : -1), 32'd0);
    drain(30);

    // Idle: nothing happens for 10 cycles
    snap_r0 = rsp_count[0]; snap_r1 = rsp_count[1];
    snap_dmwr = dmwr_seen; snap_g = grant_log.size();
    repeat (10) step();
    check("idle_rsp", 32'(rsp_count[0] + rsp_count[1] - snap_r0 - snap_r1), 32'd0);
    check("idle_wr", 32'(dmwr_seen - snap_dmwr), 32'd0);
    check("idle_ready", 32'(grant_log.size() - snap_g), 32'd0);

    // Randomized traffic on both ports
    for (int i = 0; i < 600; i++) begin
      if (q0.size() == 0 && $urandom_range(0, 2) != 0)
        q0.push_back(mk($urandom_range(0, 63), $urandom, 1'($urandom), $urandom_range(0, 3)));
      if (q1.size() == 0 && $urandom_range(0, 2) != 0)
        q1.push_back(mk($urandom_range(0, 63), $urandom, 1'($urandom), $urandom_range(0, 3)));
      step();
    end
    drain(40);
    for (int w = 0; w < 16; w++)
      check($sformatf("mem_word%0d", w), env_mem[w],
            {sh[4*w+3], sh[4*w+2], sh[4*w+1], sh[4*w]});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
